// File: rtl/bemicro_cv_pio_pkg.sv
// Shared constants for the BeMicro CV PIO blocks: the s1 register map and the
// bit positions inside STATUS.
package bemicro_cv_pio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_BLINKEN = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd5;

    localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/bemicro_cv_led_pio_if.sv
// Avalon-MM s1 slave bundle for the LED PIO. The master side is the Nios II
// data master (or a testbench); the slave side is the PIO register file.
interface bemicro_cv_led_pio_if;
    import bemicro_cv_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/bemicro_cv_blink_prescaler.sv
// Blink phase generator: a down-counter reloaded with period-1 at terminal
// count, toggling phase each time it expires. `period` carries the register
// value that will hold after this edge, so on a PERIOD write (load=1) the
// counter starts from the new value in the same cycle.
module bemicro_cv_blink_prescaler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] period,
    input  logic        load,
    output logic        phase
);

    logic [31:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;

    // next counter/phase; a load wins over a coincident terminal count
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load) begin
            cnt_d   = (period == '0) ? '0 : period - 32'd1;
            phase_d = 1'b0;
        end else if (period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d   = period - 32'd1;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - 32'd1;
        end
    end

    // counter and phase registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/bemicro_cv_led_pio.sv
// LED output PIO on the Nios II data master: DATA register with atomic
// set/clear aliases, per-bit blink enable and a shared blink prescaler.
// readdata and out_port are both registered from pre-edge register values.
module bemicro_cv_led_pio
    import bemicro_cv_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bemicro_cv_led_pio_if.slave  s1,
    output logic [WIDTH-1:0]     out_port
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] blinken_q, blinken_d;
    logic [31:0]      period_q, period_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] out_port_q, out_port_d;
    logic             period_load;
    logic             phase;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;

    assign wr_en = s1.chipselect && !s1.write_n;
    assign wdata = s1.writedata[WIDTH-1:0];

    // register-file write decode
    always_comb begin
        data_d      = data_q;
        blinken_d   = blinken_q;
        period_d    = period_q;
        period_load = 1'b0;
        if (wr_en) begin
            case (s1.address)
                ADDR_DATA:    data_d    = wdata;
                ADDR_BLINKEN: blinken_d = wdata;
                ADDR_PERIOD: begin
                    period_d    = s1.writedata;
                    period_load = 1'b1;
                end
                ADDR_OUTSET:  data_d    = data_q | wdata;
                ADDR_OUTCLR:  data_d    = data_q & ~wdata;
                default: ;
            endcase
        end
    end

    // read mux (ungated by chipselect) and LED drive, both from current state
    always_comb begin
        readdata_d = '0;
        case (s1.address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = data_q;
            ADDR_BLINKEN: readdata_d[WIDTH-1:0] = blinken_q;
            ADDR_PERIOD:  readdata_d            = period_q;
            ADDR_STATUS:  readdata_d[STATUS_PHASE_BIT] = phase;
            default: ;
        endcase
        out_port_d = data_q & ~(blinken_q & {WIDTH{phase}});
    end

    // state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            blinken_q  <= '0;
            period_q   <= '0;
            readdata_q <= '0;
            out_port_q <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            blinken_q  <= blinken_d;
            period_q   <= period_d;
            readdata_q <= readdata_d;
            out_port_q <= out_port_d;
        end
    end

    bemicro_cv_blink_prescaler u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_d),
        .load    (period_load),
        .phase   (phase)
    );

    assign s1.readdata = readdata_q;
    assign out_port    = out_port_q;

endmodule

// File: tb/tb_bemicro_cv_led_pio.sv
// Scoreboard bench for bemicro_cv_led_pio (WIDTH=8, RESET_VALUE=8'h5A).
// Stimulus drives on negedge and queues the value expected after the next
// posedge; the monitor compares on the following negedge.
module tb_bemicro_cv_led_pio;
    import bemicro_cv_pio_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] out_port;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    bemicro_cv_led_pio_if bus ();

    bemicro_cv_led_pio #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s1       (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          is_out;
        string       name;
        logic [31:0] exp;
    } chk_t;

    chk_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic exp_rd(input string name, input logic [31:0] exp);
        chk_t c;
        c.cyc = cyc + 1; c.is_out = 1'b0; c.name = name; c.exp = exp;
        sb_q.push_back(c);
    endtask

    task automatic exp_out(input string name, input logic [7:0] exp);
        chk_t c;
        c.cyc = cyc + 1; c.is_out = 1'b1; c.name = name; c.exp = {24'h0, exp};
        sb_q.push_back(c);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a;
        exp_rd(name, exp);
        tick();
    endtask

    // monitor: compare every queued expectation whose edge has passed
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                chk_t c;
                c = sb_q.pop_front();
                if (c.is_out) check(c.name, {24'h0, out_port}, c.exp);
                else          check(c.name, bus.readdata, c.exp);
            end
        end
    end

    logic [6:0] ph4;
    logic [7:0] o;

    initial begin
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        ph4 = 7'b0111000;

        // 1: reset values
        repeat (2) tick();
        check("rst_out_port", {24'h0, out_port}, 32'h5A);
        check("rst_readdata", bus.readdata, 32'h0);
        reset_n = 1'b1;
        exp_out("post_rst_out", 8'h5A);
        rd("rd_data_rst", ADDR_DATA, 32'h5A);

        // 2: DATA write, set/clear aliases; read during write sees old value
        exp_rd("rd_before_wr", 32'h5A);
        wr(ADDR_DATA, 32'hA5);
        wr(ADDR_OUTSET, 32'h0F);
        exp_out("out_pre_clr", 8'hAF);
        wr(ADDR_OUTCLR, 32'h81);
        exp_out("out_after_clr", 8'h2E);
        rd("rd_data_2e", ADDR_DATA, 32'h2E);

        // 3: blink bit0 with half-period 4
        wr(ADDR_BLINKEN, 32'h01);
        wr(ADDR_DATA, 32'hFF);
        wr(ADDR_PERIOD, 32'd4);
        for (int k = 0; k < 11; k++) begin
            o = (((k / 4) % 2) == 1) ? 8'hFE : 8'hFF;
            exp_out("blink_out", o);
            rd("blink_status", ADDR_STATUS, ((k / 4) % 2));
        end

        // 4: PERIOD write on the terminal-count cycle overrides the toggle
        exp_out("tc_wr_out", 8'hFF);
        exp_rd("tc_rd_period", 32'd4);
        wr(ADDR_PERIOD, 32'd3);
        for (int m = 0; m < 7; m++) begin
            o = ph4[m] ? 8'hFE : 8'hFF;
            exp_out("p3_out", o);
            rd("p3_status", ADDR_STATUS, {31'h0, ph4[m]});
        end

        // 5: PERIOD=0 while phase=1 forces phase low; write-only/reserved read 0
        for (int m = 0; m < 2; m++) begin
            exp_out("pre_stop_out", 8'hFF);
            rd("pre_stop_status", ADDR_STATUS, 32'h0);
        end
        bus.address = ADDR_STATUS;
        exp_out("stop_wr_out", 8'hFE);
        exp_rd("stop_rd_period", 32'd3);
        wr(ADDR_PERIOD, 32'd0);
        for (int m = 0; m < 5; m++) begin
            exp_out("stopped_out", 8'hFF);
            rd("stopped_status", ADDR_STATUS, 32'h0);
        end
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'h0000_0000);
        for (int a = 4; a < 8; a++) rd("rd_wo_resv", a[2:0], 32'h0);
        rd("rd_data_ff", ADDR_DATA, 32'hFF);
        rd("rd_blinken", ADDR_BLINKEN, 32'h1);
        rd("rd_period0", ADDR_PERIOD, 32'h0);

        // 6: async reset mid-blink, then chipselect-less write is ignored
        wr(ADDR_PERIOD, 32'd1);
        bus.address = ADDR_DATA;
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", {24'h0, out_port}, 32'h5A);
        check("async_rst_rd", bus.readdata, 32'h0);
        tick();
        reset_n = 1'b1;
        bus.address    = ADDR_DATA;
        bus.writedata  = 32'h33;
        bus.write_n    = 1'b0;
        bus.chipselect = 1'b0;
        tick();
        bus.write_n = 1'b1;
        rd("rd_data_nocs", ADDR_DATA, 32'h5A);
        rd("rd_blinken_rst", ADDR_BLINKEN, 32'h0);
        rd("rd_period_rst", ADDR_PERIOD, 32'h0);
        exp_out("out_after_rst", 8'h5A);
        rd("rd_status_rst", ADDR_STATUS, 32'h0);

        // drain the scoreboard with a bound
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) tick();
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
